// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues sequential fetches and queues in-order returns for decode.
// Latency: a response accepted on one edge is at the queue head on the next cycle; the head is presented combinationally.
// Backpressure: requests stall when in-flight plus queued reaches DEPTH; a redirect flushes the queue and turns in-flight fetches stale.
module instr_fetch_queue #(
  parameter int              DBITS    = 32,
  parameter logic [DBITS-1:0] START_PC = DBITS'(64),
  parameter int              DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [DBITS-1:0] redirectPc,
  output logic             imemReqValid,
  output logic [DBITS-1:0] imemReqAddr,
  input  logic             imemReqReady,
  input  logic             imemRespValid,
  input  logic [DBITS-1:0] imemRespData,
  output logic             instValid,
  output logic [DBITS-1:0] instData,
  output logic [DBITS-1:0] instPc,
  input  logic             instReady
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DBITS-1:0] fetch_pc;
  logic [DBITS-1:0] resp_pc;
  logic [CW-1:0]    live;
  logic [CW-1:0]    stale;
  logic [CW-1:0]    count;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [DBITS-1:0] data_mem [DEPTH];
  logic [DBITS-1:0] pc_mem   [DEPTH];

  logic [CW+1:0]    occupancy;
  logic [DBITS-1:0] redirect_pc_aligned;
  logic             req_fire;
  logic             resp_take;
  logic             resp_drop;
  logic             resp_keep;
  logic             enq;
  logic             deq;

  // Everything in flight or queued counts against the queue, so every issued fetch has a guaranteed slot.
  assign occupancy    = {2'b00, live} + {2'b00, stale} + {2'b00, count};
  assign imemReqValid = occupancy < (CW+2)'(DEPTH);
  assign imemReqAddr  = fetch_pc;

  // Redirect targets are forced to word alignment.
  assign redirect_pc_aligned = redirectPc & ~DBITS'(3);

  assign req_fire  = imemReqValid & imemReqReady;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_take = imemRespValid & ((live != '0) | (stale != '0));
  assign resp_drop = resp_take & (stale != '0);
  assign resp_keep = resp_take & (stale == '0);
  // Redirect wins over same-edge enqueue and dequeue: the whole queue is flushed anyway.
  assign enq       = resp_keep & ~redirect;
  assign deq       = instValid & instReady & ~redirect;

  assign instValid = count != '0;
  assign instData  = data_mem[head];
  assign instPc    = pc_mem[head];

  // Fetch/response address tracking, in-flight accounting and queue pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= START_PC;
      resp_pc  <= START_PC;
      live     <= '0;
      stale    <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc_aligned;
      resp_pc  <= redirect_pc_aligned;
      // Everything still outstanding, including a fetch issued on this edge, becomes stale.
      stale    <= stale + live + CW'(req_fire) - CW'(resp_take);
      live     <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + DBITS'(4);
      end
      if (resp_keep) begin
        resp_pc <= resp_pc + DBITS'(4);
      end
      live  <= live + CW'(req_fire) - CW'(resp_keep);
      stale <= stale - CW'(resp_drop);
      count <= count + CW'(enq) - CW'(deq);
      if (enq) begin
        tail <= tail + AW'(1);
      end
      if (deq) begin
        head <= head + AW'(1);
      end
    end
  end

  // Queue storage; the head slot is never written while occupied, so the head is stable under stall.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[tail] <= imemRespData;
      pc_mem[tail]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a one-cycle in-order memory model.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady = 1'b0;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData = '0;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int n_req = 0;
  bit mem_hold = 1'b0;

  instr_fetch_queue dut (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect),
    .redirectPc   (redirectPc),
    .imemReqValid (imemReqValid),
    .imemReqAddr  (imemReqAddr),
    .imemReqReady (imemReqReady),
    .imemRespValid(imemRespValid),
    .imemRespData (imemRespData),
    .instValid    (instValid),
    .instData     (instData),
    .instPc       (instPc),
    .instReady    (instReady)
  );

  always #5 clk = ~clk;

  // Memory model: returns word (0xC0DE0000 | addr) one cycle after each accepted request, in order.
  logic [31:0] mq[$];
  bit          s_req;
  bit          s_resp;
  logic [31:0] s_addr;

  always @(negedge clk) begin
    s_req  = imemReqValid && imemReqReady && reset;
    s_resp = imemRespValid;
    s_addr = imemReqAddr;
  end

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      mq.delete();
      n_req = 0;
      imemRespValid = 1'b0;
      imemRespData  = '0;
    end else begin
      if (s_resp && mq.size() > 0) void'(mq.pop_front());
      if (s_req) begin
        mq.push_back(s_addr);
        n_req++;
      end
      imemRespValid = (mq.size() > 0) && !mem_hold;
      if (mq.size() > 0) imemRespData = 32'hC0DE_0000 | mq[0];
      else imemRespData = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic adv();
    step();
    smp();
  endtask

  // Holds reset across two edges, then releases it just after an edge with the given ready levels.
  task automatic do_reset(input bit rdy, input bit irdy);
    reset = 1'b0;
    redirect = 1'b0;
    mem_hold = 1'b0;
    imemReqReady = 1'b0;
    instReady = 1'b0;
    step();
    step();
    imemReqReady = rdy;
    instReady = irdy;
    reset = 1'b1;
  endtask

  logic [31:0] exp_pc [4];

  initial begin
    // Reset state
    smp();
    chk("rst_instValid", 32'(instValid), 32'd0);
    chk("rst_reqValid", 32'(imemReqValid), 32'd1);
    chk("rst_reqAddr", imemReqAddr, 32'd64);

    // Reset release and streaming
    do_reset(1'b1, 1'b1);
    smp();
    chk("s_c0_addr", imemReqAddr, 32'd64);
    chk("s_c0_iv", 32'(instValid), 32'd0);
    adv();
    chk("s_c1_addr", imemReqAddr, 32'd68);
    chk("s_c1_iv", 32'(instValid), 32'd0);
    adv();
    chk("s_c2_addr", imemReqAddr, 32'd72);
    exp_pc = '{32'd64, 32'd68, 32'd72, 32'd76};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) adv();
      chk("s_iv", 32'(instValid), 32'd1);
      chk("s_pc", instPc, exp_pc[k]);
      chk("s_data", instData, 32'hC0DE_0000 | exp_pc[k]);
    end

    // Backpressure: decode stalled
    do_reset(1'b1, 1'b0);
    smp();
    adv(); adv(); adv();
    chk("bp_c3_addr", imemReqAddr, 32'd76);
    chk("bp_c3_rv", 32'(imemReqValid), 32'd1);
    adv();
    chk("bp_c4_rv", 32'(imemReqValid), 32'd0);
    adv(); adv();
    chk("bp_c6_rv", 32'(imemReqValid), 32'd0);
    chk("bp_c6_pc", instPc, 32'd64);
    chk("bp_c6_data", instData, 32'hC0DE_0040);
    step();
    instReady = 1'b1;
    smp();
    chk("bp_c7_nreq", 32'(n_req), 32'd4);
    chk("bp_c7_pc", instPc, 32'd64);
    adv();
    chk("bp_c8_rv", 32'(imemReqValid), 32'd1);
    chk("bp_c8_addr", imemReqAddr, 32'd80);
    exp_pc = '{32'd68, 32'd72, 32'd76, 32'd80};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) adv();
      chk("bp_pc", instPc, exp_pc[k]);
      chk("bp_data", instData, 32'hC0DE_0000 | exp_pc[k]);
    end

    // Redirect with two requests in flight
    do_reset(1'b1, 1'b1);
    mem_hold = 1'b1;
    smp();
    adv();
    step();
    imemReqReady = 1'b0;
    redirect = 1'b1;
    redirectPc = 32'h200;
    smp();
    chk("rd_c2_iv", 32'(instValid), 32'd0);
    step();
    redirect = 1'b0;
    mem_hold = 1'b0;
    imemReqReady = 1'b1;
    smp();
    chk("rd_c3_iv", 32'(instValid), 32'd0);
    chk("rd_c3_addr", imemReqAddr, 32'h200);
    chk("rd_c3_rv", 32'(imemReqValid), 32'd1);
    adv();
    chk("rd_c4_iv", 32'(instValid), 32'd0);
    adv();
    chk("rd_c5_iv", 32'(instValid), 32'd0);
    adv();
    chk("rd_c6_iv", 32'(instValid), 32'd1);
    chk("rd_c6_pc", instPc, 32'h200);
    chk("rd_c6_data", instData, 32'hC0DE_0200);
    adv();
    chk("rd_c7_pc", instPc, 32'h204);

    // Redirect to unaligned target on the same edge as a request and a response
    do_reset(1'b1, 1'b1);
    smp();
    adv();
    step();
    redirect = 1'b1;
    redirectPc = 32'h203;
    smp();
    chk("ra_c2_pc", instPc, 32'd64);
    chk("ra_c2_resp", 32'(imemRespValid), 32'd1);
    step();
    redirect = 1'b0;
    smp();
    chk("ra_c3_iv", 32'(instValid), 32'd0);
    chk("ra_c3_addr", imemReqAddr, 32'h200);
    adv();
    chk("ra_c4_iv", 32'(instValid), 32'd0);
    adv();
    chk("ra_c5_iv", 32'(instValid), 32'd1);
    chk("ra_c5_pc", instPc, 32'h200);
    chk("ra_c5_data", instData, 32'hC0DE_0200);
    adv();
    chk("ra_c6_pc", instPc, 32'h204);

    // Asynchronous reset mid-stream with three entries queued
    do_reset(1'b1, 1'b0);
    smp();
    adv(); adv(); adv(); adv();
    chk("ar_c4_iv", 32'(instValid), 32'd1);
    chk("ar_c4_pc", instPc, 32'd64);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_async_iv", 32'(instValid), 32'd0);
    chk("ar_async_rv", 32'(imemReqValid), 32'd1);
    chk("ar_async_addr", imemReqAddr, 32'd64);
    step();
    step();
    imemReqReady = 1'b1;
    instReady = 1'b1;
    reset = 1'b1;
    smp();
    chk("ar_c0_addr", imemReqAddr, 32'd64);
    chk("ar_c0_iv", 32'(instValid), 32'd0);
    adv();
    chk("ar_c1_addr", imemReqAddr, 32'd68);
    adv();
    chk("ar_c2_pc", instPc, 32'd64);
    chk("ar_c2_data", instData, 32'hC0DE_0040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DBITS, default 32, instruction and address width.
REQ-002 SHALL have parameter START_PC, default 64, fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port redirect  input  1  flush and restart fetch at redirectPc.
REQ-007 SHALL have port redirectPc  input  DBITS  new fetch address.
REQ-008 SHALL have port imemReqValid  output  1  fetch request valid.
REQ-009 SHALL have port imemReqAddr  output  DBITS  fetch address.
REQ-010 SHALL have port imemReqReady  input  1  memory accepts request.
REQ-011 SHALL have port imemRespValid  input  1  in-order instruction return.
REQ-012 SHALL have port imemRespData  input  DBITS  returned instruction word.
REQ-013 SHALL have port instValid  output  1  queue head valid to decode.
REQ-014 SHALL have port instData  output  DBITS  head instruction.
REQ-015 SHALL have port instPc  output  DBITS  address of head instruction.
REQ-016 SHALL have port instReady  input  1  decode consumes head.

Function
REQ-017 SHALL treat reqFire = imemReqValid & imemReqReady, respFire = imemRespValid, deqFire = instValid & instReady.
REQ-018 SHALL drive imemReqValid = (live + stale + count) < DEPTH, using registered state only, so total in-flight plus queued never exceeds DEPTH.
REQ-019 SHALL drive imemReqAddr from register fetchPc; fetchPc += 4 on each reqFire, wrapping modulo 2^DBITS.
REQ-020 SHALL count live (in-flight, to keep) and stale (in-flight, to discard) requests; reqFire increments live.
REQ-021 SHALL, on respFire with stale > 0, decrement stale and discard the data.
REQ-022 SHALL, on respFire with stale = 0, decrement live and enqueue {imemRespData, respPc}, then respPc += 4.
REQ-023 SHALL ignore respFire when live = stale = 0 (protocol violation, no state change).
REQ-024 SHALL present the queue head combinationally on instData/instPc with instValid = (count > 0); simultaneous enqueue and dequeue keep count unchanged.
REQ-025 SHALL give one-cycle latency: response accepted in cycle N appears at head in cycle N+1 if queue was empty.
REQ-026 SHALL, on redirect, in the same edge: empty the queue; set fetchPc and respPc to {redirectPc[DBITS-1:2], 2'b00}; stale_next = stale + live + reqFire - respFire; live_next = 0.
REQ-027 SHALL give redirect priority over same-cycle reqFire (request becomes stale), respFire (data discarded), and deqFire (no effect beyond flush).
REQ-028 SHALL not change instData/instPc while instValid = 1 and instReady = 0.

Reset
REQ-029 SHALL, while reset = 0, immediately force: fetchPc = respPc = START_PC, count = live = stale = 0, imemReqValid = 1 (DEPTH > 0), instValid = 0.
REQ-030 SHALL discard any in-flight responses from before reset; memory is expected to be reset with this block.
REQ-031 SHALL begin issuing at START_PC on the first rising edge after reset returns to 1.

Verification
REQ-032 Reset release, imemReqReady=1 -> first request address 64, then 68, 72; instValid = 0 until first response.
REQ-033 Stream: responses 1 cycle after each request, instReady=1 -> instPc 64, 68, 72, 76 on consecutive cycles with matching instData.
REQ-034 Backpressure: instReady=0, DEPTH=4 -> exactly 4 requests (64..76) then imemReqValid=0; raise instReady -> next request 80, no lost or duplicated entries.
REQ-035 Redirect to 0x200 with 2 requests in flight -> those 2 responses discarded, queue empty after redirect, next instPc 0x200.
REQ-036 Redirect to 0x203 in same cycle as reqFire and respFire -> both dropped, next request address 0x200, stale accounting returns to 0.
REQ-037 Assert reset mid-stream with 3 queued entries -> instValid falls asynchronously without a clock edge; after release first request address 64.
